guess_round_ctrl: RTL
=====================

GUESS_ROUND_CTRL -- requirements
Module: guess_round_ctrl

Interface
REQ-001 Parameter RESP_LAT, default 2, cycles from enter_pulse to valid datapath flags; legal range 1..7.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn_enter  input  1  level "submit guess" button, already synchronized.
REQ-005 btn_new  input  1  level "new round" button, already synchronized.
REQ-006 max_tries  input  4  attempt limit per round; 0 = unlimited.
REQ-007 eq, lt, gt, outrange  input  1 each  compare and range flags from the guessing datapath.
REQ-008 dp_rst  output  1  one-cycle clear pulse to the datapath.
REQ-009 genrand_pulse  output  1  one-cycle target-generation pulse to the datapath.
REQ-010 enter_pulse  output  1  one-cycle guess-latch pulse to the datapath.
REQ-011 reject  output  1  one-cycle pulse: last guess out of range, not counted.
REQ-012 tries  output  4  counted guesses this round.
REQ-013 best  output  4  fewest tries over all won rounds since reset; 4'hF = none.
REQ-014 win, lose  output  1 each  round result levels.
REQ-015 state  output  3  current FSM state encoding (debug).

Function
REQ-016 All outputs registered; edge detect: btn & ~btn_prev, btn_prev registers updated every cycle.
REQ-017 FSM states: IDLE=0, CLR=1, SEED=2, PLAY=3, EVAL=4, WIN=5, LOSE=6; encodings 7 unused, recover to IDLE.
REQ-018 IDLE: btn_new edge -> CLR; btn_enter ignored.
REQ-019 CLR: dp_rst=1 for this one cycle; tries<=0; win,lose<=0; max_tries captured into internal limit; -> SEED.
REQ-020 SEED: genrand_pulse=1 for this one cycle; -> PLAY.
REQ-021 PLAY: btn_enter edge -> enter_pulse=1 for one cycle, latency counter<=0, -> EVAL.
REQ-022 EVAL: counter increments each cycle; flags sampled on the cycle counter reaches RESP_LAT-1 (RESP_LAT cycles after enter_pulse cycle); btn_enter edges during EVAL dropped.
REQ-023 EVAL sample, outrange=1: reject=1 one cycle, tries unchanged, -> PLAY.
REQ-024 EVAL sample, outrange=0, eq=1: tries<=tries+1, -> WIN.
REQ-025 EVAL sample, outrange=0, eq=0: tries<=tries+1; if limit!=0 and tries+1==limit -> LOSE, else -> PLAY.
REQ-026 tries saturates at 15; no wrap; saturated value still compared against limit.
REQ-027 WIN: win=1 held; on entry best<=min(best, tries_new); stays until btn_new edge -> CLR.
REQ-028 LOSE: lose=1 held; best unchanged; stays until btn_new edge -> CLR.
REQ-029 btn_new edge in PLAY or EVAL aborts the round -> CLR; pending EVAL result discarded, tries not incremented.
REQ-030 Simultaneous btn_new and btn_enter edges: btn_new wins, no enter_pulse.
REQ-031 lt/gt are not used for sequencing; only eq and outrange.
REQ-032 Held buttons produce exactly one edge; a new edge requires the button to drop low for >=1 cycle.

Reset
REQ-033 rst=1 at a clock edge: state<=IDLE, all pulses 0, tries<=0, best<=4'hF, win,lose<=0, counter<=0.
REQ-034 btn_prev registers reset to 1 so buttons held through reset generate no edge.
REQ-035 rst mid-round (any state) takes effect the same edge, overriding all other transitions; best is cleared.

Verification
REQ-036 Reset, btn_new pulse -> dp_rst one cycle, genrand_pulse next cycle, state=PLAY next; tries=0, best=F.
REQ-037 max_tries=3, RESP_LAT=2, guesses with eq=0,eq=0,eq=1 -> tries 1,2,3, win=1, best=3.
REQ-038 max_tries=2, two guesses eq=0 -> lose=1 after second, tries=2, best unchanged; btn_new -> CLR, lose=0.
REQ-039 Guess with outrange=1 -> reject pulse, tries unchanged, state returns to PLAY; enter held 10 cycles -> single enter_pulse.
REQ-040 Second round won in 1 try after earlier best=3 -> best=1; third won in 4 -> best stays 1.
REQ-041 btn_new and btn_enter same edge in PLAY -> no enter_pulse, dp_rst next cycle; rst in EVAL -> IDLE, best=F.

Source files
------------

// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round sequencer for a number-guessing game.
//
// The controller runs one round at a time. Each round does these steps:
// clear the datapath, generate a target, then accept guesses. Each guess
// is latched into the datapath, and the compare flags are sampled
// RESP_LAT cycles later. The round ends in WIN (eq) or LOSE (the attempt
// limit is reached). The best (fewest) winning try count is kept from
// reset onwards.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   btn_enter      level "submit guess" button (already synchronized)
//   btn_new        level "new round" button (already synchronized)
//   max_tries[3:0] attempt limit per round, 0 = unlimited
//   eq, lt, gt     compare flags from the datapath (only eq sequences)
//   outrange       guess out of legal range
//   dp_rst         one-cycle datapath clear (high while in CLR)
//   genrand_pulse  one-cycle target generation (high while in SEED)
//   enter_pulse    one-cycle guess latch (first cycle of EVAL)
//   reject         one-cycle pulse: guess was out of range, not counted
//   tries[3:0]     counted guesses this round (saturates at 15)
//   best[3:0]      fewest tries over won rounds, 4'hF = none yet
//   win, lose      round result levels
//   state[2:0]     current FSM state (debug)
module guess_round_ctrl #(
  parameter int RESP_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enter,
  input  logic       btn_new,
  input  logic [3:0] max_tries,
  input  logic       eq,
  input  logic       lt,
  input  logic       gt,
  input  logic       outrange,
  output logic       dp_rst,
  output logic       genrand_pulse,
  output logic       enter_pulse,
  output logic       reject,
  output logic [3:0] tries,
  output logic [3:0] best,
  output logic       win,
  output logic       lose,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_SEED = 3'd2,
    ST_PLAY = 3'd3,
    ST_EVAL = 3'd4,
    ST_WIN  = 3'd5,
    ST_LOSE = 3'd6
  } state_t;

  // The counter value on which the datapath flags are taken.
  localparam logic [2:0] LAT_LAST = 3'(RESP_LAT - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic       enter_prev_r;
  logic       new_prev_r;
  logic       enter_edge_s;
  logic       new_edge_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic [3:0] limit_r;
  logic [3:0] limit_nxt_s;
  logic [3:0] tries_nxt_s;
  logic [3:0] best_nxt_s;
  logic [3:0] tries_inc_s;
  logic       enter_pulse_nxt_s;
  logic       reject_nxt_s;
  logic       unused_s;

  // lt/gt only matter to the display path, not to sequencing.
  assign unused_s = lt ^ gt;

  assign enter_edge_s = btn_enter & ~enter_prev_r;
  assign new_edge_s   = btn_new & ~new_prev_r;
  assign tries_inc_s  = (tries == 4'hF) ? 4'hF : (tries + 4'd1);
  assign state        = state_r;

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    limit_nxt_s       = limit_r;
    tries_nxt_s       = tries;
    best_nxt_s        = best;
    enter_pulse_nxt_s = 1'b0;
    reject_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (new_edge_s) begin
          state_nxt_s = ST_CLR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        tries_nxt_s = 4'd0;
        limit_nxt_s = max_tries;
        state_nxt_s = ST_SEED;
      end
      ST_SEED: begin
        state_nxt_s = ST_PLAY;
      end
      ST_PLAY: begin
        // A new-round request beats a simultaneous guess.
        if (new_edge_s) begin
          state_nxt_s = ST_CLR;
        end else if (enter_edge_s) begin
          state_nxt_s       = ST_EVAL;
          enter_pulse_nxt_s = 1'b1;
          cnt_nxt_s         = 3'd0;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_EVAL: begin
        // An abort throws away the pending result. Enter edges are ignored.
        if (new_edge_s) begin
          state_nxt_s = ST_CLR;
        end else if (cnt_r == LAT_LAST) begin
          if (outrange) begin
            reject_nxt_s = 1'b1;
            state_nxt_s  = ST_PLAY;
          end else if (eq) begin
            tries_nxt_s = tries_inc_s;
            best_nxt_s  = (tries_inc_s < best) ? tries_inc_s : best;
            state_nxt_s = ST_WIN;
          end else begin
            tries_nxt_s = tries_inc_s;
            if ((limit_r != 4'd0) && (tries_inc_s == limit_r)) begin
              state_nxt_s = ST_LOSE;
            end else begin
              state_nxt_s = ST_PLAY;
            end
          end
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (new_edge_s) begin
          state_nxt_s = ST_CLR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs. Reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      enter_prev_r  <= 1'b1;
      new_prev_r    <= 1'b1;
      cnt_r         <= 3'd0;
      limit_r       <= 4'd0;
      tries         <= 4'd0;
      best          <= 4'hF;
      dp_rst        <= 1'b0;
      genrand_pulse <= 1'b0;
      enter_pulse   <= 1'b0;
      reject        <= 1'b0;
      win           <= 1'b0;
      lose          <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      enter_prev_r  <= btn_enter;
      new_prev_r    <= btn_new;
      cnt_r         <= cnt_nxt_s;
      limit_r       <= limit_nxt_s;
      tries         <= tries_nxt_s;
      best          <= best_nxt_s;
      dp_rst        <= (state_nxt_s == ST_CLR);
      genrand_pulse <= (state_nxt_s == ST_SEED);
      enter_pulse   <= enter_pulse_nxt_s;
      reject        <= reject_nxt_s;
      win           <= (state_nxt_s == ST_WIN);
      lose          <= (state_nxt_s == ST_LOSE);
    end
  end

endmodule
